// File: rtl/img_stream_loader.sv
// img_stream_loader: packs a byte-serial pixel stream into 32-bit words in memory, then hands off to the accelerator
module img_stream_loader #(
  parameter int          IMG_W     = 352,
  parameter int          IMG_H     = 288,
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int          N_WORDS   = IMG_W * IMG_H / 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] addr,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  output logic        acc_start,
  input  logic        acc_finish,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST = 16'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  lane;
  logic [15:0] word_cnt;
  logic [23:0] pack;
  logic [31:0] wr_data;
  logic        write_pend;
  logic        last_wr;
  logic        accept;

  assign we     = en;
  assign busy   = state != IDLE;
  assign addr   = BASE_ADDR + word_cnt;
  assign dataW  = wr_data;
  assign accept = pix_valid && pix_ready;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  // next state and handshake/memory/accelerator controls
  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    en        = 1'b0;
    acc_start = 1'b0;
    done      = 1'b0;
    last_wr   = write_pend && word_cnt == LAST;
    case (state)
      IDLE: state_nx = load ? FILL : IDLE;
      FILL: begin
        pix_ready = !last_wr;
        en        = write_pend;
        state_nx  = last_wr ? RUN : FILL;
      end
      RUN: begin
        acc_start = 1'b1;
        state_nx  = acc_finish ? DONE : RUN;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  // pixel packing: earlier lanes shift down so lane 0 ends up in the low byte
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lane       <= '0;
      word_cnt   <= '0;
      pack       <= '0;
      wr_data    <= '0;
      write_pend <= 1'b0;
    end else begin
      if (state == IDLE && load) begin
        lane     <= '0;
        word_cnt <= '0;
      end
      if (en) begin
        write_pend <= 1'b0;
        word_cnt   <= word_cnt + 16'd1;
      end
      if (accept) begin
        lane <= lane + 2'd1;
        pack <= {pix_in, pack[23:8]};
        if (lane == 2'd3) begin
          wr_data    <= {pix_in, pack};
          write_pend <= 1'b1;
        end
      end
    end

endmodule
